// File: rtl/vga_pkg.sv
// vga_pkg: shared FSM state, RGB565 field layout and colour channel width conversion.
package vga_pkg;
    typedef enum logic {WAIT_SOF, RUN} vga_state_t;
    localparam int R_LSB = 11;
    localparam int R_W   = 5;
    localparam int G_LSB = 5;
    localparam int G_W   = 6;
    localparam int B_LSB = 0;
    localparam int B_W   = 5;
    // Right-aligned result: narrower outputs keep the field MSBs, wider ones repeat the field from its MSB.
    function automatic logic [7:0] vga_expand_channel(input logic [7:0] field, input int src_w, input int out_w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (i < out_w) r[3'(out_w - 1 - i)] = field[3'(src_w - 1 - (i % src_w))];
        return r;
    endfunction
endpackage

// File: rtl/vga_stream_out_if.sv
// vga_stream_out_if: RGB565 AXI-Stream pixel channel from the VDMA MM2S port.
interface vga_stream_out_if;
    logic [15:0] tdata;
    logic        tuser;
    logic        tvalid;
    logic        tready;
    modport master(output tdata, tuser, tvalid, input tready);
    modport slave(input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with active-region, sync (at configured polarity) and frame-sync decode.
module vga_timing_gen #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int HSYNC_POLARITY = 0,
    parameter int VSYNC_POLARITY = 0
) (
    input  logic clk,
    input  logic rst_n,
    output logic active,
    output logic sof,
    output logic hsync,
    output logic vsync,
    output logic fsync
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic HP = 1'(HSYNC_POLARITY);
    localparam logic VP = 1'(VSYNC_POLARITY);
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    always_ff @(posedge clk)
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= (h == H_LAST) ? '0 : h + 1'b1;
            if (h == H_LAST) v <= (v == V_LAST) ? '0 : v + 1'b1;
        end
    always_comb begin
        active = (h < H_ACT) && (v < V_ACT);
        sof    = (h == '0) && (v == '0);
        hsync  = (h >= HS_BEG && h < HS_END) ? HP : ~HP;
        vsync  = (v >= VS_BEG && v < VS_END) ? VP : ~VP;
        fsync  = (h == '0) && (v == V_ACT);
    end
endmodule

// File: rtl/vga_stream_out.sv
// vga_stream_out: RGB565 AXI-Stream to VGA scan-out with tuser frame alignment and underflow blanking.
// Optional: define VGA_STREAM_OUT_UNDERFLOW_STATUS_EN to add the saturating o_Underflow_Count port.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int BITS_PER_COLOR_CHANNEL = 4,
    parameter int H_ACTIVE       = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int HSYNC_POLARITY = 0,
    parameter int VSYNC_POLARITY = 0
) (
    input  logic                              i_Clock,
    input  logic                              i_Reset_n,
    vga_stream_out_if.slave                   s_axis,
    output logic                              o_mm2s_fsync,
    output logic [BITS_PER_COLOR_CHANNEL-1:0] o_Red,
    output logic [BITS_PER_COLOR_CHANNEL-1:0] o_Green,
    output logic [BITS_PER_COLOR_CHANNEL-1:0] o_Blue,
    output logic                              o_Horizontal_Sync,
    output logic                              o_Vertical_Sync,
    output logic                              o_Frame_Error
`ifdef VGA_STREAM_OUT_UNDERFLOW_STATUS_EN
    ,
    output logic [15:0]                       o_Underflow_Count
`endif
);
    localparam int BPC = BITS_PER_COLOR_CHANNEL;
    localparam logic HP = 1'(HSYNC_POLARITY);
    localparam logic VP = 1'(VSYNC_POLARITY);
    vga_state_t state, state_next;
    logic active, sof, hsync, vsync, fsync;
    logic show, err;
    logic [BPC-1:0] red, green, blue;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .HSYNC_POLARITY(HSYNC_POLARITY), .VSYNC_POLARITY(VSYNC_POLARITY)
    ) u_timing (
        .clk(i_Clock), .rst_n(i_Reset_n), .active(active), .sof(sof),
        .hsync(hsync), .vsync(vsync), .fsync(fsync)
    );

    always_ff @(posedge i_Clock)
        if (!i_Reset_n) state <= WAIT_SOF;
        else state <= state_next;

    always_comb
        state_next = (state == WAIT_SOF) ? (show ? RUN : WAIT_SOF) : (err ? WAIT_SOF : RUN);

    // While hunting, non-SOF beats are drained and a tuser beat is parked until the raster reaches (0,0).
    always_comb begin
        s_axis.tready = 1'b0;
        show = 1'b0;
        err = 1'b0;
        if (i_Reset_n && state == WAIT_SOF) begin
            s_axis.tready = sof || !s_axis.tuser;
            show = sof && s_axis.tvalid && s_axis.tuser;
        end else if (i_Reset_n && active) begin
            s_axis.tready = (s_axis.tuser == sof);
            show = s_axis.tvalid && (s_axis.tuser == sof);
            err = s_axis.tvalid && (s_axis.tuser != sof);
        end
    end

    always_comb begin
        red   = BPC'(vga_expand_channel(8'(s_axis.tdata[R_LSB +: R_W]), R_W, BPC));
        green = BPC'(vga_expand_channel(8'(s_axis.tdata[G_LSB +: G_W]), G_W, BPC));
        blue  = BPC'(vga_expand_channel(8'(s_axis.tdata[B_LSB +: B_W]), B_W, BPC));
    end

    always_ff @(posedge i_Clock)
        if (!i_Reset_n) begin
            o_Red             <= '0;
            o_Green           <= '0;
            o_Blue            <= '0;
            o_Horizontal_Sync <= ~HP;
            o_Vertical_Sync   <= ~VP;
            o_mm2s_fsync      <= 1'b0;
            o_Frame_Error     <= 1'b0;
        end else begin
            o_Red             <= show ? red : '0;
            o_Green           <= show ? green : '0;
            o_Blue            <= show ? blue : '0;
            o_Horizontal_Sync <= hsync;
            o_Vertical_Sync   <= vsync;
            o_mm2s_fsync      <= fsync;
            o_Frame_Error     <= err;
        end

`ifdef VGA_STREAM_OUT_UNDERFLOW_STATUS_EN
    logic underflow;
    assign underflow = i_Reset_n && state == RUN && active && !s_axis.tvalid;
    always_ff @(posedge i_Clock)
        if (!i_Reset_n) o_Underflow_Count <= '0;
        else if (underflow && o_Underflow_Count != 16'hFFFF) o_Underflow_Count <= o_Underflow_Count + 1'b1;
`endif
endmodule

// File: tb/tb_vga_stream_out.sv
// tb_vga_stream_out: random pixel stream into an 8-bpc/active-low and a 4-bpc/active-high build,
// checked every cycle against a raster-position reference model plus literal pixel expectations.
module tb_vga_stream_out;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_stream_out_if ax0();
    vga_stream_out_if ax1();
    assign ax1.tdata  = ax0.tdata;
    assign ax1.tuser  = ax0.tuser;
    assign ax1.tvalid = ax0.tvalid;

    logic fs0, hs0, vs0, fe0, fs1, hs1, vs1, fe1;
    logic [7:0] r0, g0, b0;
    logic [3:0] r1, g1, b1;
`ifdef VGA_STREAM_OUT_UNDERFLOW_STATUS_EN
    logic [15:0] uc0, uc1, uc_base;
`endif

    vga_stream_out #(
        .BITS_PER_COLOR_CHANNEL(8), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .HSYNC_POLARITY(0), .VSYNC_POLARITY(0)
    ) dut0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .s_axis(ax0), .o_mm2s_fsync(fs0),
        .o_Red(r0), .o_Green(g0), .o_Blue(b0), .o_Horizontal_Sync(hs0), .o_Vertical_Sync(vs0),
        .o_Frame_Error(fe0)
`ifdef VGA_STREAM_OUT_UNDERFLOW_STATUS_EN
        , .o_Underflow_Count(uc0)
`endif
    );

    vga_stream_out #(
        .BITS_PER_COLOR_CHANNEL(4), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .HSYNC_POLARITY(1), .VSYNC_POLARITY(1)
    ) dut1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .s_axis(ax1), .o_mm2s_fsync(fs1),
        .o_Red(r1), .o_Green(g1), .o_Blue(b1), .o_Horizontal_Sync(hs1), .o_Vertical_Sync(vs1),
        .o_Frame_Error(fe1)
`ifdef VGA_STREAM_OUT_UNDERFLOW_STATUS_EN
        , .o_Underflow_Count(uc1)
`endif
    );

    int n_cmp = 0, n_err = 0;
    int pos = 0, ucnt = 0, k = 0, drop_cnt = 0;
    int fs_cnt = 0, fe_cnt = 0, lit_hits = 0, und_cnt = 0;
    bit synced = 0, inj = 0, hold = 0, det = 1, force5 = 0, last_disp = 0;
    logic [15:0] cur = '0, last_d = '0;
    int e_r8 = 0, e_g8 = 0, e_b8 = 0, e_r4 = 0, e_g4 = 0, e_b4 = 0;
    bit e_hs0 = 1, e_vs0 = 1, e_fs = 0, e_fe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Channel value = top n bits of the field written out repeatedly.
    function automatic int ex(input int f, input int w, input int n);
        int rep = 0;
        for (int i = 0; i < 4; i++) rep = (rep << w) | f;
        return rep >> (4 * w - n);
    endfunction

    function automatic logic [15:0] mk(input int idx);
        if (!det) return 16'($urandom);
        return (idx == 2) ? 16'h8410 : (idx == 3) ? 16'hFFFF : 16'(idx);
    endfunction

    task automatic cyc(input bit rn, input bit v, input bit u, input logic [15:0] d, output bit acc);
        int h, vv;
        bit act, sof, rdy, disp, err, und;
        @(negedge clk);
        chk("red8", 32'(r0), e_r8);
        chk("green8", 32'(g0), e_g8);
        chk("blue8", 32'(b0), e_b8);
        chk("red4", 32'(r1), e_r4);
        chk("green4", 32'(g1), e_g4);
        chk("blue4", 32'(b1), e_b4);
        chk("hsync_p0", 32'(hs0), 32'(e_hs0));
        chk("vsync_p0", 32'(vs0), 32'(e_vs0));
        chk("hsync_p1", 32'(hs1), 32'(!e_hs0));
        chk("vsync_p1", 32'(vs1), 32'(!e_vs0));
        chk("fsync0", 32'(fs0), 32'(e_fs));
        chk("fsync1", 32'(fs1), 32'(e_fs));
        chk("frame_err0", 32'(fe0), 32'(e_fe));
        chk("frame_err1", 32'(fe1), 32'(e_fe));
`ifdef VGA_STREAM_OUT_UNDERFLOW_STATUS_EN
        chk("ucount0", 32'(uc0), ucnt);
        chk("ucount1", 32'(uc1), ucnt);
`endif
        if (fs0) fs_cnt++;
        if (fe0) fe_cnt++;
        if (det && last_disp) begin
            if (last_d == 16'h0000) begin chk("px00_red8", 32'(r0), 32'h0); lit_hits++; end
            if (last_d == 16'h0001) begin chk("px1_blue4", 32'(b1), 32'h0); chk("px1_blue8", 32'(b0), 32'h08); lit_hits++; end
            if (last_d == 16'h8410) begin
                chk("px8410_r", 32'(r0), 32'h84); chk("px8410_g", 32'(g0), 32'h82); chk("px8410_b", 32'(b0), 32'h84);
                lit_hits++;
            end
            if (last_d == 16'hFFFF) begin
                chk("pxffff_r", 32'(r0), 32'hFF); chk("pxffff_g", 32'(g0), 32'hFF); chk("pxffff_b", 32'(b0), 32'hFF);
                lit_hits++;
            end
        end
        rst_n = rn;
        ax0.tvalid = v;
        ax0.tuser = u;
        ax0.tdata = d;
        #1;
        h = pos % HT;
        vv = (pos / HT) % VT;
        act = (h < HA) && (vv < VA);
        sof = (pos % FR) == 0;
        rdy = !rn ? 1'b0 : !synced ? (!u || sof) : (act && (u == sof));
        chk("tready0", 32'(ax0.tready), 32'(rdy));
        chk("tready1", 32'(ax1.tready), 32'(rdy));
        acc = v && rdy;
        disp = 0; err = 0; und = 0;
        if (rn && !synced) begin
            disp = sof && v && u;
            synced = disp;
        end else if (rn && act) begin
            und = !v;
            err = v && (u != sof);
            disp = v && (u == sof);
            if (err) synced = 0;
        end
        if (!rn) begin
            pos = 0; synced = 0; ucnt = 0; last_disp = 0;
            e_r8 = 0; e_g8 = 0; e_b8 = 0; e_r4 = 0; e_g4 = 0; e_b4 = 0;
            e_hs0 = 1; e_vs0 = 1; e_fs = 0; e_fe = 0;
        end else begin
            e_r8 = disp ? ex(int'(d[15:11]), 5, 8) : 0;
            e_g8 = disp ? ex(int'(d[10:5]), 6, 8) : 0;
            e_b8 = disp ? ex(int'(d[4:0]), 5, 8) : 0;
            e_r4 = disp ? ex(int'(d[15:11]), 5, 4) : 0;
            e_g4 = disp ? ex(int'(d[10:5]), 6, 4) : 0;
            e_b4 = disp ? ex(int'(d[4:0]), 5, 4) : 0;
            e_hs0 = !(h >= HA + HF && h < HA + HF + HS);
            e_vs0 = !(vv >= VA + VF && vv < VA + VF + VS);
            e_fs = (h == 0) && (vv == VA);
            e_fe = err;
            if (und) begin und_cnt++; if (ucnt < 65535) ucnt++; end
            last_disp = disp;
            last_d = d;
            pos++;
        end
    endtask

    // Frame source: beat k of 32 per frame, tuser on k==0 or on an injected misaligned beat.
    task automatic run(input int n, input int vprob, input int iprob, input bit rn);
        bit v, u, acc;
        for (int i = 0; i < n; i++) begin
            v = hold || (int'($urandom_range(99)) < vprob);
            if (drop_cnt > 0 && !hold && synced && rn && (pos % HT) < HA && ((pos / HT) % VT) < VA) begin
                v = 0;
                drop_cnt--;
            end
            if (force5 && k == 5 && !hold) begin inj = 1; force5 = 0; end
            if (!inj && !hold && k != 0 && iprob > 0 && int'($urandom_range(999)) < iprob) inj = 1;
            u = (k == 0) || inj;
            cyc(rn, v, u, cur, acc);
            hold = v && !acc;
            if (acc) begin
                k = u ? 1 : (k + 1) % 32;
                inj = 0;
                cur = mk(k);
            end
        end
    endtask

    initial begin
        ax0.tvalid = 1'b0;
        ax0.tuser = 1'b0;
        ax0.tdata = '0;
        run(3, 0, 0, 0);
        chk("hsync_idle_p0", 32'(hs0), 32'h1);
        chk("hsync_idle_p1", 32'(hs1), 32'h0);
        chk("vsync_idle_p1", 32'(vs1), 32'h0);
        run(20, 0, 0, 1);
        run(FR, 100, 0, 1);
        fs_cnt = 0;
        lit_hits = 0;
        run(3 * FR, 100, 0, 1);
        chk("fsync_pulses", fs_cnt, 3);
        chk("pixel_literals", lit_hits, 12);
        und_cnt = 0;
`ifdef VGA_STREAM_OUT_UNDERFLOW_STATUS_EN
        uc_base = uc0;
`endif
        drop_cnt = 2;
        run(FR, 100, 0, 1);
        chk("underflow_events", und_cnt, 2);
`ifdef VGA_STREAM_OUT_UNDERFLOW_STATUS_EN
        chk("underflow_count_delta", 32'(uc0) - 32'(uc_base), 2);
`endif
        run(3 * FR, 100, 0, 1);
        fe_cnt = 0;
        force5 = 1;
        run(3 * FR, 100, 0, 1);
        chk("frame_error_pulses", fe_cnt, 1);
        det = 0;
        run(20 * FR, 85, 5, 1);
        run(37, 100, 0, 1);
        run(2, 0, 0, 0);
        run(3 * FR, 100, 0, 1);
        run(1, 0, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
